shift_unit: RTL and testbench

Parametrised multi-cycle shifter for the integer execute stage. It performs logical-left, logical-right, arithmetic-right and rotate-right shifts on an XLEN-bit operand, moving at most STEP bit positions per clock. The shift amount is masked to log2(XLEN) bits, as RISC-V requires. A valid/ready handshake on both sides lets the pipeline stall on long shifts instead of building a full combinational barrel shifter.

---
 rtl/shift_unit.sv | 112 +++++++++++
 tb/tb_shift_unit.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/shift_unit.sv
// rtl/shift_unit.sv - multi-cycle SLL/SRL/SRA/ROR shifter with valid/ready handshakes
// Moves at most STEP bit positions per clock so no full barrel shifter is needed.
module shift_unit #(
    parameter int XLEN = 32,
    parameter int STEP = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] A,
    input  logic [XLEN-1:0] B,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            zero,
    output logic            busy
);
    localparam int SHW = $clog2(XLEN);
    localparam logic [SHW:0] STEP_V = STEP[SHW:0];
    localparam logic [SHW:0] XLEN_V = XLEN[SHW:0];

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_DONE
    } state_t;

    state_t          r_state, w_state_next;
    logic [XLEN-1:0] r_w, w_w_next, w_shifted;
    logic [SHW:0]    r_r, w_r_next, w_k, w_k_comp, w_r_dec;
    logic [1:0]      r_op, w_op_next;
    logic            r_s, w_s_next;
    logic            w_unused_b;

    assign w_unused_b = |B[XLEN-1:SHW];

    assign w_k      = (r_r > STEP_V) ? STEP_V : r_r;
    assign w_k_comp = XLEN_V - w_k;
    assign w_r_dec  = r_r - w_k;

    // SRA fills from the latched sign, never from the current MSB of W.
    always_comb begin
        w_shifted = r_w;
        case (r_op)
            2'b00:   w_shifted = r_w << w_k;
            2'b01:   w_shifted = r_w >> w_k;
            2'b10:   w_shifted = (r_w >> w_k) | (r_s ? ~({XLEN{1'b1}} >> w_k) : '0);
            default: w_shifted = (r_w >> w_k) | (r_w << w_k_comp);
        endcase
    end

    always_comb begin
        w_state_next = r_state;
        w_w_next     = r_w;
        w_r_next     = r_r;
        w_op_next    = r_op;
        w_s_next     = r_s;
        case (r_state)
            S_IDLE: begin
                if (in_valid) begin
                    w_w_next     = A;
                    w_r_next     = {1'b0, B[SHW-1:0]};
                    w_op_next    = op;
                    w_s_next     = A[XLEN-1];
                    w_state_next = (B[SHW-1:0] == '0) ? S_DONE : S_BUSY;
                end
            end
            S_BUSY: begin
                w_w_next = w_shifted;
                w_r_next = w_r_dec;
                if (w_r_dec == '0) w_state_next = S_DONE;
            end
            S_DONE: begin
                if (out_ready) w_state_next = S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
        if (flush) begin
            w_state_next = S_IDLE;
            w_w_next     = r_w;
            w_r_next     = r_r;
            w_op_next    = r_op;
            w_s_next     = r_s;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_w     <= '0;
            r_r     <= '0;
            r_op    <= 2'b00;
            r_s     <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_w     <= w_w_next;
            r_r     <= w_r_next;
            r_op    <= w_op_next;
            r_s     <= w_s_next;
        end
    end

    assign in_ready  = (r_state == S_IDLE);
    assign out_valid = (r_state == S_DONE);
    assign busy      = (r_state == S_BUSY) || (r_state == S_DONE);
    assign result    = r_w;
    assign zero      = (r_w == '0);

endmodule

// File: tb/tb_shift_unit.sv
// tb/tb_shift_unit.sv - self-checking bench for shift_unit
// Directed vector table, flush/reset sequences and a randomised sweep against a reference model.
module tb_shift_unit;
    logic        clk = 1'b0;
    logic        rst, flush, in_valid, out_ready;
    logic        in_ready, out_valid, zero, busy;
    logic [1:0]  op;
    logic [31:0] A, B, result;

    int n_tests = 0;
    int n_fail  = 0;

    shift_unit #(.XLEN(32), .STEP(8)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .A(A), .B(B),
        .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .zero(zero), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        z;
        int          lat;
        int          stall;
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Rotation is taken from a doubled operand; shifts use plain SV operators.
    function automatic logic [31:0] ref_shift(input logic [1:0] o, input logic [31:0] a,
                                              input logic [31:0] b);
        int          n;
        logic [63:0] dbl;
        n   = int'(b[4:0]);
        dbl = {a, a};
        case (o)
            2'b00:   return a << n;
            2'b01:   return a >> n;
            2'b10:   return $unsigned($signed(a) >>> n);
            default: return dbl[n +: 32];
        endcase
    endfunction

    function automatic int ref_lat(input logic [31:0] b);
        return 1 + (int'(b[4:0]) + 7) / 8;
    endfunction

    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          input int stall, input logic [31:0] exp_res, input string tag,
                          output logic [31:0] res, output logic z, output int lat);
        @(negedge clk);
        chk({tag, "_ready_before"}, {31'b0, in_ready}, 32'd1);
        op = o; A = a; B = b; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        A = $urandom; B = $urandom;
        lat = 1;
        while (!out_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        res = result;
        z   = zero;
        chk({tag, "_done_flags"}, {30'b0, busy, in_ready}, 32'd2);
        for (int s = 0; s < stall; s++) begin
            @(negedge clk);
            chk({tag, "_hold"}, {29'b0, out_valid, in_ready, zero}, {29'b0, 1'b1, 1'b0, exp_res == 0});
            chk({tag, "_hold_res"}, result, exp_res);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk({tag, "_idle_after"}, {29'b0, in_ready, out_valid, busy}, 32'd4);
    endtask

    logic [31:0] got_res, exp;
    logic        got_z;
    int          got_lat;
    logic [1:0]  r_op;
    logic [31:0] r_a, r_b;

    initial begin
        vecs[0] = '{2'b10, 32'h8000_0000, 32'd31,         32'hFFFF_FFFF, 1'b0, 5, 0};
        vecs[1] = '{2'b10, 32'h4000_0000, 32'd31,         32'h0000_0000, 1'b1, 5, 1};
        vecs[2] = '{2'b01, 32'hF000_0000, 32'd4,          32'h0F00_0000, 1'b0, 2, 0};
        vecs[3] = '{2'b00, 32'h0000_0001, 32'h25,         32'h0000_0020, 1'b0, 2, 0};
        vecs[4] = '{2'b00, 32'h0000_1234, 32'd0,          32'h0000_1234, 1'b0, 1, 0};
        vecs[5] = '{2'b11, 32'h0000_0001, 32'd1,          32'h8000_0000, 1'b0, 2, 0};
        vecs[6] = '{2'b11, 32'h1234_5678, 32'd20,         32'h4567_8123, 1'b0, 4, 3};
        vecs[7] = '{2'b01, 32'h8000_0000, 32'hFFFF_FFE3,  32'h1000_0000, 1'b0, 2, 0};
        vecs[8] = '{2'b11, 32'hDEAD_BEEF, 32'd0,          32'hDEAD_BEEF, 1'b0, 1, 2};

        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        op = 2'b00; A = '0; B = '0;
        repeat (3) @(negedge clk);
        chk("reset_flags", {28'b0, in_ready, out_valid, busy, zero}, 32'b1001);
        chk("reset_result", result, 32'h0);
        rst = 1'b0;

        for (int i = 0; i < 9; i++) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].stall, vecs[i].res, "vec",
                   got_res, got_z, got_lat);
            chk($sformatf("vec%0d_result", i), got_res, vecs[i].res);
            chk($sformatf("vec%0d_zero", i), {31'b0, got_z}, {31'b0, vecs[i].z});
            chk($sformatf("vec%0d_latency", i), got_lat, vecs[i].lat);
        end

        // Flush on the second BUSY cycle, with a competing request that must be dropped.
        @(negedge clk);
        op = 2'b10; A = 32'h8000_0000; B = 32'd31; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        chk("flush_busy1", {31'b0, busy}, 32'd1);
        @(negedge clk);
        flush = 1'b1; in_valid = 1'b1; op = 2'b00; A = 32'h0000_0003; B = 32'd5;
        @(negedge clk);
        flush = 1'b0; in_valid = 1'b0;
        chk("flush_idle", {29'b0, in_ready, out_valid, busy}, 32'd4);
        chk("flush_w_kept", result, 32'hFF80_0000);
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            chk("flush_quiet", {30'b0, out_valid, busy}, 32'd0);
        end

        // Reset in the middle of a long shift.
        @(negedge clk);
        op = 2'b00; A = 32'hFFFF_FFFF; B = 32'd31; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_mid_flags", {28'b0, in_ready, out_valid, busy, zero}, 32'b1001);
        chk("rst_mid_result", result, 32'h0);
        run_op(2'b00, 32'd3, 32'd2, 0, 32'hC, "post_rst", got_res, got_z, got_lat);
        chk("post_rst_result", got_res, 32'h0000_000C);
        chk("post_rst_latency", got_lat, 2);

        for (int i = 0; i < 160; i++) begin
            r_op = 2'($urandom_range(0, 3));
            r_a  = (i % 10 == 0) ? 32'h0 : $urandom;
            r_b  = $urandom;
            exp  = ref_shift(r_op, r_a, r_b);
            run_op(r_op, r_a, r_b, $urandom_range(0, 3), exp, "rnd", got_res, got_z, got_lat);
            chk($sformatf("rnd%0d_op%0d_n%0d_result", i, r_op, r_b[4:0]), got_res, exp);
            chk($sformatf("rnd%0d_zero", i), {31'b0, got_z}, {31'b0, exp == 0});
            chk($sformatf("rnd%0d_latency", i), got_lat, ref_lat(r_b));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
